misr_multi: RTL



---
 rtl/misr_pkg.sv | 37 +++
 rtl/misr_lane.sv | 64 ++++++
 rtl/misr_multi.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/misr_pkg.sv
// Shared types and helpers for the multi-lane LBIST MISR.
// Holds the FSM state enum, default POLY/SEED constants and the word-folding function.
package misr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HASH,
        DONE
    } state_e;

    localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
    localparam logic [31:0] DEF_SEED = 32'h0000_0000;

    // Widest CUT word / signature the fold helper handles.
    localparam int FOLD_W = 256;

    // Bit j of the CUT word lands on signature bit (j mod sig_bits).
    // This zero-extends narrow words, and XORs the sig_bits-wide chunks
    // of wide words, with the last chunk zero-padded.
    function automatic logic [FOLD_W-1:0] fold(
        input logic [FOLD_W-1:0] data,
        input int                cut_bits,
        input int                sig_bits
    );
        logic [FOLD_W-1:0] r;
        int                k;
        r = '0;
        for (int j = 0; j < FOLD_W; j++) begin
            if (j < cut_bits) begin
                k = j % sig_bits;
                r[k[7:0]] = r[k[7:0]] ^ data[j[7:0]];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/misr_lane.sv
// One MISR lane: signature register, accepted-word counter and update logic.
// Ports: load_seed/accept/data/target in; sig, done (count==target), last (count+1==target) out.
module misr_lane
    import misr_pkg::*;
#(
    parameter int                      CUT_MSG_BITS   = 32,
    parameter int                      SIGNATURE_BITS = 32,
    parameter int                      CW             = 6,
    parameter logic [SIGNATURE_BITS-1:0] POLY         = '0,
    parameter logic [SIGNATURE_BITS-1:0] SEED         = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_seed,
    input  logic                      accept,
    input  logic [CUT_MSG_BITS-1:0]   data,
    input  logic [CW-1:0]             target,
    output logic [SIGNATURE_BITS-1:0] sig,
    output logic                      done,
    output logic                      last
);

    logic [SIGNATURE_BITS-1:0] sig_q, sig_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [FOLD_W-1:0]         data_ext;
    logic [SIGNATURE_BITS-1:0] folded;

    always_comb begin
        data_ext                   = '0;
        data_ext[CUT_MSG_BITS-1:0] = data;
    end

    assign folded = SIGNATURE_BITS'(fold(data_ext, CUT_MSG_BITS, SIGNATURE_BITS));

    always_comb begin
        sig_d = sig_q;
        cnt_d = cnt_q;
        if (load_seed) begin
            sig_d = SEED;
            cnt_d = '0;
        end else if (accept) begin
            sig_d = {sig_q[SIGNATURE_BITS-2:0], 1'b0}
                  ^ (sig_q[SIGNATURE_BITS-1] ? POLY : '0)
                  ^ folded;
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= SEED;
            cnt_q <= '0;
        end else begin
            sig_q <= sig_d;
            cnt_q <= cnt_d;
        end
    end

    assign sig  = sig_q;
    assign done = (cnt_q == target);
    // Lookahead so the FSM can leave HASH on the edge of the final beat.
    assign last = ((cnt_q + CW'(1)) == target);

endmodule

// File: rtl/misr_multi.sv
// Multi-channel LBIST MISR: NUM_CHANNELS lanes compacted in parallel, one response.
// Ports: cut_req_* (per-lane val/rdy/msg), lbist_req_* (start), lbist_resp_* (signatures).
// Optional MISR_TIMEOUT_EN: TIMEOUT_CYCLES parameter and lbist_resp_timeout output.
module misr_multi
    import misr_pkg::*;
#(
    parameter int          NUM_CHANNELS        = 4,
    parameter int          CUT_MSG_BITS        = 32,
    parameter int          SIGNATURE_BITS      = 32,
    parameter logic [31:0] POLY                = DEF_POLY,
    parameter logic [31:0] SEED                = DEF_SEED,
    parameter int          MAX_OUTPUTS_TO_HASH = 32,
    parameter int          LBIST_MSG_BITS      = $clog2(MAX_OUTPUTS_TO_HASH)
`ifdef MISR_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYCLES      = 1024
`endif
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_CHANNELS-1:0]                cut_req_val,
    input  logic [NUM_CHANNELS*CUT_MSG_BITS-1:0]   cut_req_msg,
    output logic [NUM_CHANNELS-1:0]                cut_req_rdy,
    input  logic                                   lbist_req_val,
    input  logic [LBIST_MSG_BITS:0]                lbist_req_msg,
    output logic                                   lbist_req_rdy,
    output logic                                   lbist_resp_val,
    output logic [NUM_CHANNELS*SIGNATURE_BITS-1:0] lbist_resp_msg,
    input  logic                                   lbist_resp_rdy
`ifdef MISR_TIMEOUT_EN
    ,
    output logic                                   lbist_resp_timeout
`endif
);

    localparam int            CW      = LBIST_MSG_BITS + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTPUTS_TO_HASH);

    state_e                  state_q, state_d;
    logic [CW-1:0]           target_q, target_d;
    logic [CW-1:0]           req_clamped;
    logic                    load_seed;
    logic [NUM_CHANNELS-1:0] accept, done, last, fin;

    assign req_clamped = (lbist_req_msg > MAX_CNT) ? MAX_CNT : lbist_req_msg;

    // Ready depends only on registered state and counts, never on val.
    assign cut_req_rdy = (state_q == HASH) ? ~done : '0;
    assign accept      = cut_req_val & cut_req_rdy;
    assign fin         = done | (accept & last);

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_lane
        misr_lane #(
            .CUT_MSG_BITS  (CUT_MSG_BITS),
            .SIGNATURE_BITS(SIGNATURE_BITS),
            .CW            (CW),
            .POLY          (SIGNATURE_BITS'(POLY)),
            .SEED          (SIGNATURE_BITS'(SEED))
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .load_seed(load_seed),
            .accept   (accept[i]),
            .data     (cut_req_msg[i*CUT_MSG_BITS +: CUT_MSG_BITS]),
            .target   (target_q),
            .sig      (lbist_resp_msg[i*SIGNATURE_BITS +: SIGNATURE_BITS]),
            .done     (done[i]),
            .last     (last[i])
        );
    end

`ifdef MISR_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [IW-1:0] idle_q, idle_d;
    logic          timeout_q, timeout_d;
    assign lbist_resp_timeout = timeout_q;
`endif

    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        load_seed      = 1'b0;
        lbist_req_rdy  = 1'b0;
        lbist_resp_val = 1'b0;
`ifdef MISR_TIMEOUT_EN
        timeout_d      = timeout_q;
        idle_d         = idle_q;
        if (load_seed || (|accept)) begin
            idle_d = '0;
        end else if (state_q == HASH) begin
            idle_d = idle_q + IW'(1);
        end
`endif
        unique case (state_q)
            IDLE: begin
                lbist_req_rdy = 1'b1;
                if (lbist_req_val) begin
                    target_d  = req_clamped;
                    load_seed = 1'b1;
                    state_d   = (req_clamped == '0) ? DONE : HASH;
                end
            end
            HASH: begin
                if (&fin) begin
                    state_d = DONE;
                end
`ifdef MISR_TIMEOUT_EN
                else if (idle_q == IW'(TIMEOUT_CYCLES - 1) && !(|accept)) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
`endif
            end
            DONE: begin
                lbist_resp_val = 1'b1;
                if (lbist_resp_rdy) begin
                    state_d = IDLE;
`ifdef MISR_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef MISR_TIMEOUT_EN
        // Seed load happens in IDLE, so clear the idle count on HASH entry too.
        if (load_seed) begin
            idle_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

`ifdef MISR_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end
`endif

endmodule
